rr_arbiter: RTL and testbench
=============================

// Module: rr_arbiter
// PURPOSE
//  N-way parametrised arbiter. Successor to the 2-requester FSM arbiter.
//  Adds round-robin or fixed priority, direct grant handover with no IDLE bubble, and a bounded hold time.
//  Sits between NUM_REQ bus masters and one shared resource. Grants are registered, one-hot and state-decoded.
// PARAMETERS
//  NUM_REQ   4   number of requesters, >=2
//  RR_MODE   1   1: round-robin priority; 0: fixed priority, index 0 highest
//  MAX_HOLD  8   max consecutive grant cycles per owner; 0 = unlimited
//  IDW       $clog2(NUM_REQ)  width of gnt_id (derived localparam, not overridable)
// PORTS
//  clock      in   1        single clock, rising edge
//  reset_n    in   1        asynchronous, active-low reset
//  req        in   NUM_REQ  request vector; level, held until done
//  gnt        out  NUM_REQ  grant vector; one-hot or all zero
//  gnt_valid  out  1        |gnt
//  gnt_id     out  IDW      index of current owner; 0 when gnt_valid=0
// BEHAVIOUR
//  - Reset (reset_n=0, async): gnt=0, gnt_valid=0, gnt_id=0, state=IDLE, rr_ptr=0, hold_cnt=0.
//  - States: IDLE (no owner) and GRANT (owner valid). Outputs decode from registered state/owner only.
//  - Winner pick:
//    - RR_MODE=1: first set req bit searching from rr_ptr upward, wrapping NUM_REQ-1 -> 0.
//    - RR_MODE=0: lowest set index.
//  - IDLE: any req -> GRANT to winner; gnt visible 1 cycle after req sampled. No req -> stay IDLE.
//  - GRANT, req[owner]=1 and (MAX_HOLD=0 or hold_cnt<MAX_HOLD-1): keep owner; hold_cnt++.
//  - GRANT, req[owner]=0: if another req is set, hand over to winner next cycle, with no idle cycle.
//    Otherwise -> IDLE.
//  - GRANT, hold limit reached (hold_cnt==MAX_HOLD-1) with req[owner]=1:
//    - another req set: forced handover to winner, with owner excluded from the pick.
//    - no other req: keep owner; hold_cnt reset to 0.
//  - On every owner change: rr_ptr = (new_owner+1) mod NUM_REQ; hold_cnt=0. rr_ptr is unused when RR_MODE=0.
//  - Entering GRANT from IDLE also updates rr_ptr and clears hold_cnt.
//  - Simultaneous events: owner deasserts in the same cycle another asserts -> handover in the next cycle.
//  - All-ones req in RR mode with owner dropping: the pick starts at owner+1.
//  - Mid-operation reset: outputs clear immediately (async) without waiting for a clock edge.
//    First grant after reset_n rises follows the IDLE rules with rr_ptr=0.
//  - Invariants: at most one gnt bit set. gnt never asserted to an index whose req was 0 at the last sample edge.
//  - Illegal/unused state encodings -> IDLE on the next clock.
// CONFIGURATION
//  ARB_LOCK_EN defined:
//    - Adds input port lock (1 bit, after req).
//    - While lock=1 and req[owner]=1, the hold limit is ignored and the owner keeps the grant. hold_cnt saturates.
//    - lock has no effect in IDLE or when req[owner]=0.
//  ARB_LOCK_EN undefined: no lock port; the hold limit is always enforced.
// STRUCTURE
//  - Package arb_pkg:
//    - state typedef/localparams ARB_IDLE=1'b0, ARB_GRANT=1'b1
//    - mode constants ARB_MODE_FIXED=0, ARB_MODE_RR=1
//    - function clog2_min1()
//  - Sub-module arb_rr_pick (combinational):
//    - inputs: req, start pointer, exclude mask
//    - outputs: winner index, found flag
//    - implemented as a doubled-vector priority search. Instantiated once.
//  - Top holds the state register, owner, rr_ptr and hold_cnt ($clog2(MAX_HOLD+1) bits), plus output decode.
// TESTING
//  1. Reset: reset_n=0 with req=4'b1111 -> gnt=0, gnt_id=0. Release: the next edge grants 0001, and gnt is visible 1 cycle later.
//  2. RR rotation: req=1111 held, MAX_HOLD=0, each owner drops req for 1 cycle in turn.
//     -> grants 0001,0010,0100,1000,0001 with no gnt=0 cycle between them.
//  3. Hold limit: MAX_HOLD=8, req=0011 constant -> gnt 0001 for 8 cycles, then 0010 for 8 cycles, alternating.
//     With req=0001 only -> 0001 held indefinitely.
//  4. Fixed mode: RR_MODE=0, req=0110, then req[0] set while 0010 is owned.
//     -> 0010 holds until it drops or hits the hold limit, then 0001 wins over 0100.
//  5. Async reset mid-grant: gnt=0100, pulse reset_n low between clock edges -> gnt=0 immediately.
//     After release with req=0100 -> 0100 after 1 cycle, rr_ptr restarted at 0.
//  6. ARB_LOCK_EN: MAX_HOLD=4, req=0011, lock=1 -> 0001 held for 20 cycles. lock=0 -> handover to 0010 within 1 cycle.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types and helpers for the N-way bus arbiter.
// Provides state encoding, priority mode constants and a width helper.
package arb_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_t;

    localparam int ARB_MODE_FIXED = 0;
    localparam int ARB_MODE_RR    = 1;

    // $clog2 that never returns less than 1, so vectors stay legal
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/arb_rr_pick.sv
// Combinational priority search starting at a pointer, with wrap-around.
// Ports: req, start, excl (mask of bits to ignore) -> win (index), found.
module arb_rr_pick
    import arb_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]                 req,
    input  logic [clog2_min1(NUM_REQ)-1:0]     start,
    input  logic [NUM_REQ-1:0]                 excl,
    output logic [clog2_min1(NUM_REQ)-1:0]     win,
    output logic                               found
);

    localparam int IDW = clog2_min1(NUM_REQ);
    localparam int DW  = clog2_min1(2 * NUM_REQ);

    logic [NUM_REQ-1:0]   masked;
    logic [2*NUM_REQ-1:0] dbl;
    logic [DW-1:0]        k;
    logic [DW-1:0]        w;

    assign masked = req & ~excl;

    // Doubling the vector turns the wrapping search into a linear scan
    always_comb begin
        dbl   = {masked, masked};
        found = 1'b0;
        win   = '0;
        k     = '0;
        w     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            k = DW'(start) + DW'(i);
            if (!found && dbl[k]) begin
                found = 1'b1;
                w     = (k >= DW'(NUM_REQ)) ? k - DW'(NUM_REQ) : k;
                win   = w[IDW-1:0];
            end
        end
    end

endmodule

// File: rtl/rr_arbiter.sv
// N-way arbiter: round-robin or fixed priority, bounded hold, registered one-hot grant.
// Ports: clock, reset_n (async low), req, [lock if ARB_LOCK_EN], gnt, gnt_valid, gnt_id.
module rr_arbiter
    import arb_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int RR_MODE  = 1,
    parameter int MAX_HOLD = 8
) (
    input  logic                           clock,
    input  logic                           reset_n,
    input  logic [NUM_REQ-1:0]             req,
`ifdef ARB_LOCK_EN
    input  logic                           lock,
`endif
    output logic [NUM_REQ-1:0]             gnt,
    output logic                           gnt_valid,
    output logic [clog2_min1(NUM_REQ)-1:0] gnt_id
);

    localparam int IDW = clog2_min1(NUM_REQ);
    localparam int HW  = clog2_min1(MAX_HOLD + 1);
    localparam bit HOLD_EN = (MAX_HOLD > 0);
    localparam logic [HW-1:0] HOLD_LAST =
        HW'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);

    arb_state_t     state, state_d;
    logic [IDW-1:0] owner, owner_d;
    logic [IDW-1:0] rr_ptr, ptr_d;
    logic [HW-1:0]  hold_cnt, hold_d;

    logic [NUM_REQ-1:0] own_mask;
    logic [NUM_REQ-1:0] excl;
    logic [IDW-1:0]     start;
    logic [IDW-1:0]     win;
    logic               found;
    logic               own_req;
    logic               limit;
    logic               lock_hold;

`ifdef ARB_LOCK_EN
    assign lock_hold = lock;
`else
    assign lock_hold = 1'b0;
`endif

    function automatic logic [IDW-1:0] next_ptr(input logic [IDW-1:0] i);
        return (i == IDW'(NUM_REQ - 1)) ? '0 : i + 1'b1;
    endfunction

    assign own_mask = NUM_REQ'(1) << owner;
    assign own_req  = |(req & own_mask);
    assign limit    = HOLD_EN && (hold_cnt == HOLD_LAST) && !lock_hold;
    assign start    = (RR_MODE == ARB_MODE_RR) ? rr_ptr : '0;

    // Only a forced handover keeps the current owner out of the pick
    assign excl = (state == ARB_GRANT && own_req && limit)
                ? own_mask : '0;

    arb_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req   (req),
        .start (start),
        .excl  (excl),
        .win   (win),
        .found (found)
    );

    always_comb begin
        state_d = state;
        owner_d = owner;
        ptr_d   = rr_ptr;
        hold_d  = hold_cnt;
        case (state)
            ARB_IDLE: begin
                if (found) begin
                    state_d = ARB_GRANT;
                    owner_d = win;
                    ptr_d   = next_ptr(win);
                    hold_d  = '0;
                end
            end
            ARB_GRANT: begin
                if (own_req && !limit) begin
                    // Saturates at the last value while locked
                    if (HOLD_EN && hold_cnt != HOLD_LAST)
                        hold_d = hold_cnt + 1'b1;
                end else if (found) begin
                    owner_d = win;
                    ptr_d   = next_ptr(win);
                    hold_d  = '0;
                end else if (own_req) begin
                    hold_d = '0;
                end else begin
                    state_d = ARB_IDLE;
                    hold_d  = '0;
                end
            end
            default: begin
                state_d = ARB_IDLE;
                hold_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ARB_IDLE;
            owner    <= '0;
            rr_ptr   <= '0;
            hold_cnt <= '0;
        end else begin
            state    <= state_d;
            owner    <= owner_d;
            rr_ptr   <= ptr_d;
            hold_cnt <= hold_d;
        end
    end

    assign gnt_valid = (state == ARB_GRANT);
    assign gnt       = gnt_valid ? own_mask : '0;
    assign gnt_id    = gnt_valid ? owner : '0;

endmodule

// File: tb/tb_rr_arbiter.sv
// Directed self-checking bench for rr_arbiter with three configurations.
// Covers reset, RR rotation, hold limit, fixed priority, async reset, and lock.
module tb_rr_arbiter;

    logic       clock = 1'b0;
    logic       reset_n;
    logic [3:0] req_a, req_b, req_c;
    logic [3:0] gnt_a, gnt_b, gnt_c;
    logic       valid_a, valid_b, valid_c;
    logic [1:0] id_a, id_b, id_c;
`ifdef ARB_LOCK_EN
    logic       lock;
`endif

    int checks = 0;
    int errors = 0;

    logic [3:0] drops [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    logic [3:0] exps  [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [1:0] ids   [4] = '{2'd1, 2'd2, 2'd3, 2'd0};

    always #5 clock = ~clock;

    rr_arbiter #(.NUM_REQ(4), .RR_MODE(1), .MAX_HOLD(0)) dut_a (
        .clock     (clock),
        .reset_n   (reset_n),
        .req       (req_a),
`ifdef ARB_LOCK_EN
        .lock      (lock),
`endif
        .gnt       (gnt_a),
        .gnt_valid (valid_a),
        .gnt_id    (id_a)
    );

    rr_arbiter #(.NUM_REQ(4), .RR_MODE(1), .MAX_HOLD(8)) dut_b (
        .clock     (clock),
        .reset_n   (reset_n),
        .req       (req_b),
`ifdef ARB_LOCK_EN
        .lock      (lock),
`endif
        .gnt       (gnt_b),
        .gnt_valid (valid_b),
        .gnt_id    (id_b)
    );

    rr_arbiter #(.NUM_REQ(4), .RR_MODE(0), .MAX_HOLD(4)) dut_c (
        .clock     (clock),
        .reset_n   (reset_n),
        .req       (req_c),
`ifdef ARB_LOCK_EN
        .lock      (lock),
`endif
        .gnt       (gnt_c),
        .gnt_valid (valid_c),
        .gnt_id    (id_c)
    );

    task automatic chk(input string tag, input logic [3:0] obs,
                       input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    initial begin
        reset_n = 1'b0;
        req_a   = 4'b1111;
        req_b   = 4'b0000;
        req_c   = 4'b0000;
`ifdef ARB_LOCK_EN
        lock    = 1'b0;
`endif
        step(2);
        chk("rst_gnt", gnt_a, 4'b0000);
        chk("rst_id", {2'b00, id_a}, 4'd0);
        chk("rst_valid", {3'b000, valid_a}, 4'd0);
        reset_n = 1'b1;
        chk("rel_before_edge", gnt_a, 4'b0000);
        step(1);
        chk("first_gnt", gnt_a, 4'b0001);
        chk("first_valid", {3'b000, valid_a}, 4'd1);

        for (int i = 0; i < 4; i++) begin
            req_a = drops[i];
            step(1);
            chk("rr_rot_gnt", gnt_a, exps[i]);
            chk("rr_rot_id", {2'b00, id_a}, {2'b00, ids[i]});
        end
        req_a = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            step(1);
            chk("unlimited_hold", gnt_a, 4'b0001);
        end

        req_b = 4'b0011;
        for (int i = 0; i < 8; i++) begin
            step(1);
            chk("hold_own0", gnt_b, 4'b0001);
        end
        for (int i = 0; i < 8; i++) begin
            step(1);
            chk("hold_own1", gnt_b, 4'b0010);
            chk("hold_own1_id", {2'b00, id_b}, 4'd1);
        end
        step(1);
        chk("hold_back0", gnt_b, 4'b0001);
        req_b = 4'b0001;
        for (int i = 0; i < 20; i++) begin
            step(1);
            chk("hold_alone", gnt_b, 4'b0001);
        end
        req_b = 4'b0000;
        step(1);
        chk("b_idle", gnt_b, 4'b0000);

        req_c = 4'b0110;
        step(1);
        chk("fix_first", gnt_c, 4'b0010);
        req_c = 4'b0111;
        for (int i = 0; i < 3; i++) begin
            step(1);
            chk("fix_hold", gnt_c, 4'b0010);
        end
        step(1);
        chk("fix_limit", gnt_c, 4'b0001);
        chk("fix_limit_id", {2'b00, id_c}, 4'd0);
        req_c = 4'b0110;
        step(1);
        chk("fix_drop", gnt_c, 4'b0010);
        req_c = 4'b0000;
        step(1);
        chk("fix_idle", gnt_c, 4'b0000);
        chk("fix_idle_id", {2'b00, id_c}, 4'd0);
        chk("fix_idle_valid", {3'b000, valid_c}, 4'd0);

`ifdef ARB_LOCK_EN
        req_c = 4'b0011;
        lock  = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step(1);
            chk("lock_hold", gnt_c, 4'b0001);
        end
        lock = 1'b0;
        step(1);
        chk("lock_release", gnt_c, 4'b0010);
        req_c = 4'b0000;
`endif

        req_a = 4'b0100;
        step(1);
        chk("pre_rst_gnt", gnt_a, 4'b0100);
        req_a = 4'b0001;
        step(1);
        chk("pre_rst_own0", gnt_a, 4'b0001);
        req_a = 4'b0011;
        step(1);
        chk("pre_rst_keep0", gnt_a, 4'b0001);
        #3;
        reset_n = 1'b0;
        #1;
        chk("async_clr_gnt", gnt_a, 4'b0000);
        chk("async_clr_valid", {3'b000, valid_a}, 4'd0);
        reset_n = 1'b1;
        #1;
        chk("async_no_edge", gnt_a, 4'b0000);
        step(1);
        chk("post_rst_ptr0", gnt_a, 4'b0001);

        req_a = 4'b0100;
        step(1);
        #3;
        reset_n = 1'b0;
        #1;
        chk("async2_clr", gnt_a, 4'b0000);
        reset_n = 1'b1;
        step(1);
        chk("post_rst2_gnt", gnt_a, 4'b0100);
        chk("post_rst2_id", {2'b00, id_a}, 4'd2);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
